// File: rtl/param_def.sv
// param_def: shared datapath widths for the SIMD array
`ifndef PARAM_DEF_SV
`define PARAM_DEF_SV
`define MAC_BW 16
`endif

// File: rtl/simd_dispatch.sv
// simd_dispatch: operand vector dispatch with mode-switch drain; SIMD_DISPATCH_PERF_EN adds perf counters
`ifndef MAC_BW
`include "param_def.sv"
`endif
module simd_dispatch #(
  parameter int LANES = 64,
  parameter int DRAIN_CYC = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_mode,
  input  logic [LANES-1:0][`MAC_BW-1:0] in_A,
  input  logic [LANES-1:0][`MAC_BW-1:0] in_B,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [1:0]                    mode,
  output logic [LANES-1:0][`MAC_BW-1:0] iA,
  output logic [LANES-1:0][`MAC_BW-1:0] iB,
  output logic                          busy
`ifdef SIMD_DISPATCH_PERF_EN
  ,
  output logic [31:0]                   issue_cnt,
  output logic [31:0]                   drain_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, VALID, DRAIN} state_t;
  state_t state;
  logic [LANES-1:0][`MAC_BW-1:0] regA, regB;
  logic [1:0] cur_mode, pend_mode;
  logic [3:0] cnt;
  logic first_op;
  logic accept, same;
  always_comb begin
    in_ready = rst ? 1'b0 : state == IDLE ? 1'b1 : (state == VALID) && out_ready;
    out_valid = !rst && state == VALID;
    busy = !rst && state != IDLE;
    mode = cur_mode;
    iA = out_valid ? regA : '0;
    iB = out_valid ? regB : '0;
    accept = in_valid && in_ready;
    same = first_op || in_mode == cur_mode;
  end
  // a capture is only possible in IDLE or VALID; DRAIN ignores upstream entirely
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_mode <= '0;
      pend_mode <= '0;
      cnt <= '0;
      first_op <= 1'b1;
      regA <= '0;
      regB <= '0;
    end else if (state == DRAIN) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd0) begin
        cur_mode <= pend_mode;
        state <= VALID;
      end
    end else if (accept) begin
      regA <= in_A;
      regB <= in_B;
      if (same) begin
        cur_mode <= in_mode;
        first_op <= 1'b0;
        state <= VALID;
      end else begin
        pend_mode <= in_mode;
        cnt <= 4'(DRAIN_CYC - 1);
        state <= DRAIN;
      end
    end else if (state == VALID && out_ready) begin
      state <= IDLE;
    end
  end
`ifdef SIMD_DISPATCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      if (out_valid && out_ready && issue_cnt != '1) issue_cnt <= issue_cnt + 32'd1;
      if (state == DRAIN && drain_cnt != '1) drain_cnt <= drain_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_simd_dispatch.sv
// tb_simd_dispatch: table-driven vectors plus hand sequences for stall, reset-in-drain and counters
`ifndef MAC_BW
`include "param_def.sv"
`endif
module tb_simd_dispatch;
  localparam int LANES = 64;
  localparam int DRAIN_CYC = 4;
  typedef logic [`MAC_BW-1:0] word_t;
  typedef logic [LANES-1:0][`MAC_BW-1:0] vec_t;
  typedef struct {
    logic v; logic [1:0] m; logic [15:0] a; logic r;
    logic ev; logic er; logic [1:0] em; logic [15:0] ea; logic eb;
  } rec_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] in_mode = 2'd0;
  vec_t in_A = '0, in_B = '0;
  logic in_ready, out_valid, busy;
  logic [1:0] mode;
  vec_t iA, iB;
`ifdef SIMD_DISPATCH_PERF_EN
  logic [31:0] issue_cnt, drain_cnt;
`endif
  int total = 0, bad = 0;
  rec_t tbl[21];
  simd_dispatch #(.LANES(LANES), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_A(in_A), .in_B(in_B), .out_ready(out_ready), .out_valid(out_valid), .mode(mode),
    .iA(iA), .iB(iB), .busy(busy)
`ifdef SIMD_DISPATCH_PERF_EN
    , .issue_cnt(issue_cnt), .drain_cnt(drain_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic vec_t mkv(input logic [15:0] w);
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = word_t'(w) + word_t'(i);
    return v;
  endfunction
  function automatic rec_t mk(input logic v, input logic [1:0] m, input logic [15:0] a, input logic r,
                              input logic ev, input logic er, input logic [1:0] em, input logic [15:0] ea, input logic eb);
    rec_t t;
    t.v = v; t.m = m; t.a = a; t.r = r; t.ev = ev; t.er = er; t.em = em; t.ea = ea; t.eb = eb;
    return t;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  task automatic chkv(input string n, input vec_t a, input vec_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got_lane0=%0h want_lane0=%0h", n, a[0], e[0]);
    end
  endtask
  task automatic drive(input logic v, input logic [1:0] m, input logic [15:0] a, input logic r);
    in_valid = v;
    in_mode = m;
    in_A = mkv(a);
    in_B = mkv(a ^ 16'h5a5a);
    out_ready = r;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 2'd0, 16'h0, 1'b1);
    #1 chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mode", 64'(mode), 64'd0);
    chkv("rst_iA", iA, '0);
  endtask
  initial begin
    int seen;
    tbl[0]  = mk(1, 0, 16'h1, 1, 0, 1, 0, 16'h0, 0);
    tbl[1]  = mk(1, 0, 16'h2, 1, 1, 1, 0, 16'h1, 1);
    tbl[2]  = mk(1, 0, 16'h3, 1, 1, 1, 0, 16'h2, 1);
    tbl[3]  = mk(1, 0, 16'h4, 1, 1, 1, 0, 16'h3, 1);
    tbl[4]  = mk(1, 3, 16'h9, 1, 1, 1, 0, 16'h4, 1);
    tbl[5]  = mk(0, 0, 16'h0, 1, 0, 0, 0, 16'h0, 1);
    tbl[6]  = mk(0, 0, 16'h0, 1, 0, 0, 0, 16'h0, 1);
    tbl[7]  = mk(0, 0, 16'h0, 1, 0, 0, 0, 16'h0, 1);
    tbl[8]  = mk(0, 0, 16'h0, 1, 0, 0, 0, 16'h0, 1);
    tbl[9]  = mk(0, 0, 16'h0, 1, 1, 1, 3, 16'h9, 1);
    tbl[10] = mk(1, 3, 16'h7, 0, 0, 1, 3, 16'h0, 0);
    tbl[11] = mk(1, 1, 16'h8, 0, 1, 0, 3, 16'h7, 1);
    tbl[12] = mk(0, 0, 16'h0, 1, 1, 1, 3, 16'h7, 1);
    tbl[13] = mk(0, 0, 16'h0, 1, 0, 1, 3, 16'h0, 0);
    tbl[14] = mk(1, 1, 16'h6, 1, 0, 1, 3, 16'h0, 0);
    tbl[15] = mk(0, 0, 16'h0, 1, 0, 0, 3, 16'h0, 1);
    tbl[16] = mk(0, 0, 16'h0, 1, 0, 0, 3, 16'h0, 1);
    tbl[17] = mk(0, 0, 16'h0, 1, 0, 0, 3, 16'h0, 1);
    tbl[18] = mk(0, 0, 16'h0, 1, 0, 0, 3, 16'h0, 1);
    tbl[19] = mk(0, 0, 16'h0, 1, 1, 1, 1, 16'h6, 1);
    tbl[20] = mk(0, 0, 16'h0, 1, 0, 1, 1, 16'h0, 0);
    // first op after reset goes straight to VALID regardless of mode
    do_reset();
    @(negedge clk);
    drive(1'b1, 2'd2, 16'h0, 1'b1);
    in_A = '0; in_B = '0;
    in_A[0] = word_t'(5); in_B[0] = word_t'(5);
    #1 chk("first_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0, 1'b1);
    #1;
    chk("first_out_valid", 64'(out_valid), 64'd1);
    chk("first_mode", 64'(mode), 64'd2);
    chk("first_iA0", 64'(iA[0]), 64'd5);
    chk("first_iB0", 64'(iB[0]), 64'd5);
    chk("first_iA1", 64'(iA[1]), 64'd0);
    // streaming, mode switch and drain gaps
    do_reset();
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      drive(tbl[k].v, tbl[k].m, tbl[k].a, tbl[k].r);
      #1;
      chk($sformatf("t%0d_out_valid", k), 64'(out_valid), 64'(tbl[k].ev));
      chk($sformatf("t%0d_in_ready", k), 64'(in_ready), 64'(tbl[k].er));
      chk($sformatf("t%0d_mode", k), 64'(mode), 64'(tbl[k].em));
      chk($sformatf("t%0d_busy", k), 64'(busy), 64'(tbl[k].eb));
      chkv($sformatf("t%0d_iA", k), iA, tbl[k].ev ? mkv(tbl[k].ea) : '0);
      chkv($sformatf("t%0d_iB", k), iB, tbl[k].ev ? mkv(tbl[k].ea ^ 16'h5a5a) : '0);
    end
    // ten-cycle backpressure: held vector stable, nothing new accepted
    do_reset();
    @(negedge clk);
    drive(1'b1, 2'd0, 16'h11, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1'b1, 2'd0, 16'h22, 1'b0);
      #1;
      chk($sformatf("stall%0d_out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_in_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("stall%0d_mode", k), 64'(mode), 64'd0);
      chkv($sformatf("stall%0d_iA", k), iA, mkv(16'h11));
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0, 1'b1);
    #1 chkv("stall_release_iA", iA, mkv(16'h11));
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 if (out_valid) seen++;
    end
    chk("stall_extra_deliveries", 64'(seen), 64'd0);
    // reset on the second drain cycle discards the pending vector
    do_reset();
    @(negedge clk);
    drive(1'b1, 2'd0, 16'h1, 1'b1);
    @(negedge clk);
    drive(1'b1, 2'd2, 16'h2, 1'b1);
    #1 chkv("rd_deliver_iA", iA, mkv(16'h1));
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0, 1'b1);
    #1 chk("rd_drain1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rd_drain2_out_valid", 64'(out_valid), 64'd0);
    chk("rd_drain2_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rd_after_out_valid", 64'(out_valid), 64'd0);
    chk("rd_after_mode", 64'(mode), 64'd0);
    chk("rd_after_busy", 64'(busy), 64'd0);
    chk("rd_after_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1 if (out_valid) seen++;
    end
    chk("rd_never_delivered", 64'(seen), 64'd0);
`ifdef SIMD_DISPATCH_PERF_EN
    do_reset();
    chk("perf_reset_issue", 64'(issue_cnt), 64'd0);
    @(negedge clk);
    drive(1'b1, 2'd0, 16'h1, 1'b1);
    @(negedge clk);
    drive(1'b1, 2'd3, 16'h2, 1'b1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      drive(1'b0, 2'd0, 16'h0, 1'b1);
    end
    #1;
    chk("perf_issue_cnt", 64'(issue_cnt), 64'd2);
    chk("perf_drain_cnt", 64'(drain_cnt), 64'd4);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
